// File: rtl/tc_uart_pkg.sv
// Shared encodings and helpers for the Tiny Computer buffered RS-232 device.
package tc_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // RX and TX walk the same state sequence, so they share one encoding.
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/tc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as 0 while empty.
module tc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so push on full succeeds with a pop.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tc_uart_fifo.sv
// Buffered RS-232 device for the Tiny Computer I/O bus: RX/TX FIFOs,
// oversampled receiver, optional parity and sticky error flags.
module tc_uart_fifo
  import tc_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxD,
  output logic                 TxD,
  input  logic                 readRX,
  output logic                 charReady,
  output logic [DATA_BITS-1:0] RXchar,
  input  logic                 writeTX,
  input  logic [DATA_BITS-1:0] TXchar,
  output logic                 TXempty,
  output logic                 txIdle,
  input  logic                 clrErr,
  output logic                 rxOverrun,
  output logic                 rxFrameErr,
  output logic                 rxParityErr
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY == PAR_ODD);

  // Free-running oversample tick
  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Receiver
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 rx, rx_fall;
  uart_state_t          rx_st;
  logic [SW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bits;
  logic [DATA_BITS-1:0] rx_shift, rx_char;
  logic                 rx_par_bad, rx_push, frame_evt, par_evt;
  logic                 rx_empty, rx_full, ovr_evt;

  assign rx      = rx_s2;
  assign rx_fall = rx_s3 & ~rx_s2;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_st      <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bits    <= '0;
      rx_shift   <= '0;
      rx_char    <= '0;
      rx_par_bad <= 1'b0;
      rx_push    <= 1'b0;
      frame_evt  <= 1'b0;
      par_evt    <= 1'b0;
    end else begin
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
      par_evt   <= 1'b0;
      case (rx_st)
        ST_IDLE: if (rx_fall) begin
          rx_cnt <= '0;
          rx_st  <= ST_START;
        end
        ST_START: if (tick) begin
          if (rx_cnt == S_HALF) begin
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_par_bad <= 1'b0;
            rx_st      <= rx ? ST_IDLE : ST_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        ST_DATA: if (tick) begin
          if (rx_cnt == S_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx, rx_shift[DATA_BITS-1:1]};
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == B_LAST) rx_st <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        ST_PARITY: if (tick) begin
          if (rx_cnt == S_LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= (^rx_shift) ^ rx ^ ODD;
            rx_st      <= ST_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        ST_STOP: if (tick) begin
          if (rx_cnt == S_LAST) begin
            rx_cnt    <= '0;
            rx_push   <= 1'b1;
            rx_char   <= rx_shift;
            frame_evt <= ~rx;
            par_evt   <= rx_par_bad;
            rx_st     <= ST_IDLE;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_st <= ST_IDLE;
      endcase
    end
  end

  tc_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(Clock), .rst(Reset), .push(rx_push), .din(rx_char), .pop(readRX),
    .dout(RXchar), .empty(rx_empty), .full(rx_full)
  );

  assign charReady = ~rx_empty;
  assign ovr_evt   = rx_push & rx_full & ~readRX;

  // A fresh error in the clearing cycle keeps its flag set.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxOverrun   <= 1'b0;
      rxFrameErr  <= 1'b0;
      rxParityErr <= 1'b0;
    end else begin
      rxOverrun   <= (rxOverrun   & ~clrErr) | ovr_evt;
      rxFrameErr  <= (rxFrameErr  & ~clrErr) | frame_evt;
      rxParityErr <= (rxParityErr & ~clrErr) | par_evt;
    end
  end

  // Transmitter
  uart_state_t          tx_st;
  logic [SW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bits;
  logic [DATA_BITS-1:0] tx_shift, tx_head;
  logic                 tx_par, tx_empty, tx_full, tx_pop, bit_end;

  assign bit_end = tick && (tx_cnt == S_LAST);
  // Reloading from the last stop tick keeps back-to-back frames gapless.
  assign tx_pop  = !tx_empty && ((tx_st == ST_IDLE) || (tx_st == ST_STOP && bit_end));

  tc_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(Clock), .rst(Reset), .push(writeTX), .din(TXchar), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  assign TXempty = ~tx_full;
  assign txIdle  = tx_empty && (tx_st == ST_IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tx_st    <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      TxD      <= 1'b1;
    end else if (tx_pop) begin
      tx_shift <= tx_head;
      tx_par   <= (^tx_head) ^ ODD;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      TxD      <= 1'b0;
      tx_st    <= ST_START;
    end else begin
      if (tick) tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_st)
        ST_IDLE: TxD <= 1'b1;
        ST_START: if (bit_end) begin
          TxD      <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_st    <= ST_DATA;
        end
        ST_DATA: if (bit_end) begin
          tx_bits <= tx_bits + 1'b1;
          if (tx_bits == B_LAST) begin
            TxD   <= (PARITY != PAR_NONE) ? tx_par : 1'b1;
            tx_st <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            TxD      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end
        ST_PARITY: if (bit_end) begin
          TxD   <= 1'b1;
          tx_st <= ST_STOP;
        end
        ST_STOP: if (bit_end) tx_st <= ST_IDLE;
        default: tx_st <= ST_IDLE;
      endcase
    end
  end

endmodule
